// File: rtl/rom_port_arbiter.sv
// Shares one single-port synchronous ROM between instruction fetch (IF) and data load (LD).
// LD wins by default; IF is forced through after MAX_WAIT consecutive denied cycles.
module rom_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_gnt,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_rvalid,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LD = 1'b1;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [WAIT_W-1:0]     r_wait_cnt;

  logic w_can_grant;
  logic w_if_force;
  logic w_resp;
  logic w_ld_gnt;
  logic w_if_gnt;

  // Grants are only issued when the port is free this cycle; reset masks everything.
  assign w_can_grant = !reset &&
                       ((r_state == ST_IDLE) || ((r_state == ST_BUSY) && rom_rdata_valid));
  assign w_if_force  = if_req && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_ld_gnt    = w_can_grant && ld_req && !w_if_force;
  assign w_if_gnt    = w_can_grant && if_req && !w_ld_gnt;
  assign w_resp      = !reset && rom_rdata_valid &&
                       ((r_state == ST_BUSY) || (r_state == ST_STALL));

  assign ld_gnt    = w_ld_gnt;
  assign if_gnt    = w_if_gnt;
  assign if_rvalid = w_resp && (r_owner == OWNER_IF);
  assign ld_rvalid = w_resp && (r_owner == OWNER_LD);
  assign if_rdata  = rom_rdata;
  assign ld_rdata  = rom_rdata;
  assign rom_addr  = w_ld_gnt ? ld_addr : (w_if_gnt ? if_addr : r_last_addr);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ld_gnt || w_if_gnt) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (!rom_rdata_valid)            w_state_nxt = ST_STALL;
        else if (w_ld_gnt || w_if_gnt)   w_state_nxt = ST_BUSY;
        else                             w_state_nxt = ST_IDLE;
      end
      ST_STALL: begin
        if (rom_rdata_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Owner, held address and IF starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWNER_IF;
      r_last_addr <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_ld_gnt) begin
        r_owner     <= OWNER_LD;
        r_last_addr <= ld_addr;
      end else if (w_if_gnt) begin
        r_owner     <= OWNER_IF;
        r_last_addr <= if_addr;
      end
      if (!if_req || w_if_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule
